// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: EX redirect, ID handshake, instruction-memory port and IF/ID outputs.
// The master modport is the fetch unit; the slave modport is its environment.
interface if_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] PC_IF;
    logic [31:0] NPC_IF;
    logic [31:0] inst_if;
    logic        fetch_stall;

    modport master (
        input  redirect_valid, redirect_pc, if_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, if_valid, PC_IF, NPC_IF, inst_if, fetch_stall
    );

    modport slave (
        output redirect_valid, redirect_pc, if_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, if_valid, PC_IF, NPC_IF, inst_if, fetch_stall
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: one outstanding imem read, single output slot toward ID,
// EX redirects re-steer fetch and discard any stale in-flight response.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_unit_if.master fetch_io
);
    // State encoding is {outstanding, drop}.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b10,
        DROP = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] inst_q, inst_d;

    logic issue;
    logic transfer;
    logic fill;

    // A new request may only go out when the slot is empty or emptying this edge.
    assign issue = rst_n & ~fetch_io.redirect_valid & (state_q == IDLE)
                 & (~slot_valid_q | fetch_io.if_ready);
    assign transfer = slot_valid_q & fetch_io.if_ready;
    assign fill     = (state_q == WAIT) & fetch_io.imem_rvalid & ~fetch_io.redirect_valid;

    always_comb begin
        // NOTE: every next-state value is defaulted first, so no branch can infer a latch.
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        slot_valid_d = slot_valid_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        inst_d       = inst_q;

        unique case (state_q)
            IDLE: if (issue) state_d = WAIT;
            WAIT: begin
                if (fetch_io.imem_rvalid)         state_d = IDLE;
                else if (fetch_io.redirect_valid) state_d = DROP;
            end
            DROP: if (fetch_io.imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fetch_io.redirect_valid) begin
            fetch_pc_d = fetch_io.redirect_pc & ~32'h0000_0003;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (issue) req_pc_d = fetch_pc_q;

        // Empty slot is all zeros so it doubles as the IF/ID flush encoding.
        if (fetch_io.redirect_valid || (transfer && !fill)) begin
            slot_valid_d = 1'b0;
            pc_d         = '0;
            npc_d        = '0;
            inst_d       = '0;
        end else if (fill) begin
            slot_valid_d = 1'b1;
            pc_d         = req_pc_q;
            npc_d        = req_pc_q + 32'd4;
            inst_d       = fetch_io.imem_rdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= '0;
            slot_valid_q <= 1'b0;
            pc_q         <= '0;
            npc_q        <= '0;
            inst_q       <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            slot_valid_q <= slot_valid_d;
            pc_q         <= pc_d;
            npc_q        <= npc_d;
            inst_q       <= inst_d;
        end
    end

    assign fetch_io.imem_req    = issue;
    assign fetch_io.imem_addr   = fetch_pc_q;
    assign fetch_io.if_valid    = slot_valid_q;
    assign fetch_io.PC_IF       = pc_q;
    assign fetch_io.NPC_IF      = npc_q;
    assign fetch_io.inst_if     = inst_q;
    assign fetch_io.fetch_stall = ~slot_valid_q;
endmodule
